// File: rtl/ander_pkg.sv
// Purpose: shared parameters and helpers for the ander pipelined AND unit.
package ander_pkg;

  localparam int unsigned DEFAULT_WIDTH   = 1;
  localparam int unsigned DEFAULT_LATENCY = 1;
  localparam int unsigned MAX_LATENCY     = 4;

  // True when a WIDTH/LATENCY pair is legal for ander.
  function automatic bit params_ok(input int unsigned width, input int unsigned latency);
    return (width >= 1) && (latency >= 1) && (latency <= MAX_LATENCY);
  endfunction

endpackage

// File: rtl/ander_stage.sv
// Purpose: one pipeline register stage of ander (valid + data + all/any flags).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_valid             upstream stage valid
//   i_data/i_all/i_any  upstream payload, loaded only when i_valid=1
//   o_valid             registered valid (copied every edge)
//   o_data/o_all/o_any  registered payload (holds during bubbles)
module ander_stage
  import ander_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_all,
  input  logic             i_any,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_all,
  output logic             o_any
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_all;
  logic             r_any;

  // Valid always advances; payload loads only on valid so bubbles hold the last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_all   <= 1'b0;
      r_any   <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
        r_all  <= i_all;
        r_any  <= i_any;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_all   = r_all;
  assign o_any   = r_any;

endmodule

// File: rtl/ander.sv
// Purpose: registered, pipelined bitwise AND with valid strobe and all/any flags.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     a/b valid this cycle
//   a, b         operands (WIDTH bits)
//   out_valid    result/flags valid, LATENCY-1 edges after the capture edge
//   result       a & b from the last valid input
//   res_all      &result
//   res_any      |result
module ander
  import ander_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned LATENCY = DEFAULT_LATENCY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             res_all,
  output logic             res_any
);

  // Reject illegal configurations at elaboration time.
  if (!params_ok(WIDTH, LATENCY)) begin : g_bad_params
    $error("ander: WIDTH must be >=1 and LATENCY in 1..%0d", MAX_LATENCY);
  end

  logic [WIDTH-1:0] w_ab;

  // Index 0 is the combinational input; index k+1 is the output of stage k.
  logic [LATENCY:0]            w_valid;
  logic [LATENCY:0][WIDTH-1:0] w_data;
  logic [LATENCY:0]            w_all;
  logic [LATENCY:0]            w_any;

  assign w_ab       = a & b;
  assign w_valid[0] = in_valid;
  assign w_data[0]  = w_ab;
  assign w_all[0]   = &w_ab;
  assign w_any[0]   = |w_ab;

  for (genvar k = 0; k < int'(LATENCY); k++) begin : g_stage
    ander_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_valid[k]),
      .i_data  (w_data[k]),
      .i_all   (w_all[k]),
      .i_any   (w_any[k]),
      .o_valid (w_valid[k+1]),
      .o_data  (w_data[k+1]),
      .o_all   (w_all[k+1]),
      .o_any   (w_any[k+1])
    );
  end

  assign out_valid = w_valid[LATENCY];
  assign result    = w_data[LATENCY];
  assign res_all   = w_all[LATENCY];
  assign res_any   = w_any[LATENCY];

endmodule

// File: tb/tb_ander.sv
module tb_ander;

  logic clk;
  logic rst_n;

  // WIDTH=1, LATENCY=1 instance
  logic v1, a1, b1;
  logic ov1, r1, all1, any1;

  // WIDTH=8 instances (LATENCY=1 and LATENCY=3) share inputs
  logic       v8;
  logic [7:0] a8, b8;
  logic       ov8, all8, any8;
  logic [7:0] r8;
  logic       ov3, all3, any3;
  logic [7:0] r3;

  int n_checks = 0;
  int n_pass   = 0;

  ander #(.WIDTH(1), .LATENCY(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1),
    .out_valid(ov1), .result(r1), .res_all(all1), .res_any(any1)
  );

  ander #(.WIDTH(8), .LATENCY(1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8),
    .out_valid(ov8), .result(r8), .res_all(all8), .res_any(any8)
  );

  ander #(.WIDTH(8), .LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8),
    .out_valid(ov3), .result(r3), .res_all(all3), .res_any(any3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ov1, r1, all1, any1} !== 4'b0)
      $display("FAIL reset_w1: got %b want 0000", {ov1, r1, all1, any1});
    else n_pass++;
    n_checks++;
    if ({ov8, r8, all8, any8} !== 11'b0 || {ov3, r3, all3, any3} !== 11'b0)
      $display("FAIL reset_w8: got w8=%h l3=%h want 0", {ov8, r8, all8, any8}, {ov3, r3, all3, any3});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ov1 !== 1'b0 || ov8 !== 1'b0 || ov3 !== 1'b0)
      $display("FAIL reset_release: got valids %b%b%b want 000", ov1, ov8, ov3);
    else n_pass++;
  endtask

  task automatic test_width1();
    logic [2:0] vec [4];
    vec[0] = 3'b000; vec[1] = 3'b010; vec[2] = 3'b111; vec[3] = 3'b100;
    for (int i = 0; i < 4; i++) begin
      v1 = 1'b1; a1 = vec[i][2]; b1 = vec[i][1];
      @(negedge clk);
      n_checks++;
      if ({ov1, r1, all1, any1} !== {1'b1, vec[i][0], vec[i][0], vec[i][0]})
        $display("FAIL w1_vec%0d: got v/r/all/any=%b want %b", i, {ov1, r1, all1, any1},
                 {1'b1, vec[i][0], vec[i][0], vec[i][0]});
      else n_pass++;
    end
    v1 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ov1 !== 1'b0 || r1 !== 1'b0)
      $display("FAIL w1_bubble: got v=%b r=%b want v=0 r=0", ov1, r1);
    else n_pass++;
  endtask

  task automatic test_width8();
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [7:0] vr [3];
    logic [1:0] vf [3];  // {all, any}
    va[0] = 8'hF0; vb[0] = 8'h3C; vr[0] = 8'h30; vf[0] = 2'b01;
    va[1] = 8'hFF; vb[1] = 8'hFF; vr[1] = 8'hFF; vf[1] = 2'b11;
    va[2] = 8'h0F; vb[2] = 8'hF0; vr[2] = 8'h00; vf[2] = 2'b00;
    for (int i = 0; i < 3; i++) begin
      v8 = 1'b1; a8 = va[i]; b8 = vb[i];
      @(negedge clk);
      n_checks++;
      if (ov8 !== 1'b1 || r8 !== vr[i] || {all8, any8} !== vf[i])
        $display("FAIL w8_vec%0d: got v=%b r=%h all/any=%b want v=1 r=%h all/any=%b",
                 i, ov8, r8, {all8, any8}, vr[i], vf[i]);
      else n_pass++;
    end
    v8 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_latency3();
    v8 = 1'b1; a8 = 8'hAA; b8 = 8'hAA;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      v8 = 1'b0;
      n_checks++;
      if (ov3 !== (c == 3))
        $display("FAIL l3_pulse_c%0d: got out_valid=%b want %b", c, ov3, (c == 3));
      else n_pass++;
      if (c >= 3) begin
        n_checks++;
        if (r3 !== 8'hAA || {all3, any3} !== 2'b01)
          $display("FAIL l3_data_c%0d: got r=%h all/any=%b want r=aa all/any=01", c, r3, {all3, any3});
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic [7:0] vr [4];
    logic [1:0] vf [4];
    va[0] = 8'h12; vb[0] = 8'h34; vr[0] = 8'h10; vf[0] = 2'b01;
    va[1] = 8'hFF; vb[1] = 8'h0F; vr[1] = 8'h0F; vf[1] = 2'b01;
    va[2] = 8'hA5; vb[2] = 8'h5A; vr[2] = 8'h00; vf[2] = 2'b00;
    va[3] = 8'hC3; vb[3] = 8'hFF; vr[3] = 8'hC3; vf[3] = 2'b01;
    for (int c = 1; c <= 7; c++) begin
      if (c <= 4) begin
        v8 = 1'b1; a8 = va[c-1]; b8 = vb[c-1];
      end else begin
        v8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
      end
      @(negedge clk);
      if (c <= 4) begin
        n_checks++;
        if (ov8 !== 1'b1 || r8 !== vr[c-1])
          $display("FAIL b2b_w8_c%0d: got v=%b r=%h want v=1 r=%h", c, ov8, r8, vr[c-1]);
        else n_pass++;
      end
      if (c >= 3 && c <= 6) begin
        n_checks++;
        if (ov3 !== 1'b1 || r3 !== vr[c-3] || {all3, any3} !== vf[c-3])
          $display("FAIL b2b_l3_c%0d: got v=%b r=%h f=%b want v=1 r=%h f=%b",
                   c, ov3, r3, {all3, any3}, vr[c-3], vf[c-3]);
        else n_pass++;
      end
    end
    n_checks++;
    if (ov3 !== 1'b0 || r3 !== 8'hC3 || {all3, any3} !== 2'b01)
      $display("FAIL b2b_bubble: got v=%b r=%h f=%b want v=0 r=c3 f=01", ov3, r3, {all3, any3});
    else n_pass++;
    n_checks++;
    if (ov8 !== 1'b0 || r8 !== 8'hC3)
      $display("FAIL b2b_w8_bubble: got v=%b r=%h want v=0 r=c3", ov8, r8);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    v8 = 1'b1; a8 = 8'h7E; b8 = 8'hFF;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ov3 !== 1'b1 || r3 !== 8'h7E)
      $display("FAIL mrst_pre: got v=%b r=%h want v=1 r=7e", ov3, r3);
    else n_pass++;
    // Assert reset between edges; outputs must clear with no clock edge.
    #1;
    rst_n = 1'b0;
    v8 = 1'b0;
    #1;
    n_checks++;
    if ({ov3, r3, all3, any3} !== 11'b0 || {ov8, r8, all8, any8} !== 11'b0)
      $display("FAIL mrst_async: got l3=%h w8=%h want 0", {ov3, r3, all3, any3}, {ov8, r8, all8, any8});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (ov3 !== 1'b0 || r3 !== 8'h00)
        $display("FAIL mrst_stale_c%0d: got v=%b r=%h want v=0 r=00", c, ov3, r3);
      else n_pass++;
    end
  endtask

  task automatic test_idle_toggle();
    v8 = 1'b1; a8 = 8'h66; b8 = 8'hF6;
    @(negedge clk);
    v8 = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ov3 !== 1'b1 || r3 !== 8'h66)
      $display("FAIL idle_load: got v=%b r=%h want v=1 r=66", ov3, r3);
    else n_pass++;
    for (int c = 1; c <= 5; c++) begin
      a8 = ~a8; b8 = b8 ^ 8'h5A;
      @(negedge clk);
      n_checks++;
      if (ov3 !== 1'b0 || r3 !== 8'h66 || ov8 !== 1'b0 || r8 !== 8'h66)
        $display("FAIL idle_c%0d: got l3 v=%b r=%h w8 v=%b r=%h want v=0 r=66", c, ov3, r3, ov8, r8);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    v8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    @(negedge clk);
    test_reset();
    test_width1();
    test_width8();
    test_latency3();
    test_back_to_back();
    test_mid_reset();
    test_idle_toggle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
